// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN activation stage: sequencer state
// encodings and default datapath dimensions.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ARRAY_SIZE = 9;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } relu_state_e;

endpackage : cnn_pkg

// File: rtl/relu_out_fifo.sv
// Two-entry synchronous FIFO holding {last, data} results from the ReLU
// array. A push is accepted when there is room or when a pop frees the
// slot in the same cycle; a pop on an empty FIFO is ignored.
module relu_out_fifo #(
    parameter int WIDTH = 145
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against occupancy and work out the next count.
    always_comb begin
        pop_ok_s  = pop && (count_q != 2'd0);
        push_ok_s = push && ((count_q != 2'd2) || pop_ok_s);
        count_d   = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; a reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (push_ok_s) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Storage: contents need no reset, occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == 2'd0);

endmodule : relu_out_fifo

// File: rtl/relu_stage_ctrl.sv
// Sequencer for the ReLU lane array. Accepts one layer of vectors from the
// accumulator stream, drives the array's input/enable (masking tail lanes
// of a short final vector), captures the array result one cycle later and
// buffers it in a two-entry FIFO that feeds the downstream stream.
module relu_stage_ctrl
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [CNT_WIDTH-1:0]             num_elems,
    output logic                             busy,
    output logic                             done,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] s_data,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] relu_in,
    output logic [ARRAY_SIZE-1:0]            relu_en,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] relu_out,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] m_data,
    output logic                             m_last
);

    localparam int VEC_W = DATA_WIDTH * ARRAY_SIZE;
    localparam logic [CNT_WIDTH-1:0] LANES = CNT_WIDTH'(ARRAY_SIZE);

    relu_state_e          state_q;
    relu_state_e          state_d;
    logic [CNT_WIDTH-1:0] rem_q;
    logic [CNT_WIDTH-1:0] rem_d;
    logic                 p_valid_q;
    logic                 p_last_q;

    logic [ARRAY_SIZE-1:0] lane_mask_s;
    logic                  final_s;
    logic                  issue_s;
    logic [2:0]            credit_s;
    logic                  ready_s;

    logic [VEC_W:0]        fifo_dout_s;
    logic [1:0]            fifo_count_s;
    logic                  fifo_empty_s;

    // Lane i is live while more than i elements remain; a full vector
    // enables every lane. Final vector once the remainder fits in one.
    always_comb begin
        lane_mask_s = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            lane_mask_s[i] = (rem_q > CNT_WIDTH'(i));
        end
        final_s = (rem_q <= LANES);
    end

    // Credit counts the in-flight result as occupied, and a same-cycle pop
    // frees nothing, so the FIFO can never be pushed while full.
    always_comb begin
        credit_s = {1'b0, fifo_count_s} + {2'b00, p_valid_q};
        if ((state_q == ST_RUN) && (credit_s < 3'd2)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        issue_s = s_valid && ready_s;
        if (issue_s) begin
            relu_en = lane_mask_s;
        end else begin
            relu_en = '0;
        end
    end

    // Next-state and remaining-element logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d = num_elems;
                    if (num_elems == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s) begin
                    if (rem_q >= LANES) begin
                        rem_d = rem_q - LANES;
                    end else begin
                        rem_d = '0;
                    end
                    if (final_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s && !p_valid_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, remaining count and the one-cycle array-latency pipeline flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            p_valid_q <= issue_s;
            p_last_q  <= issue_s && final_s;
        end
    end

    relu_out_fifo #(
        .WIDTH (VEC_W + 1)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (p_valid_q),
        .din   ({p_last_q, relu_out}),
        .pop   (m_ready),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    assign relu_in = s_data;
    assign s_ready = ready_s;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign m_valid = !fifo_empty_s;
    assign m_data  = fifo_dout_s[VEC_W-1:0];
    assign m_last  = fifo_dout_s[VEC_W] && !fifo_empty_s;

endmodule : relu_stage_ctrl

// File: tb/tb_relu_stage_ctrl.sv
// Directed bench for relu_stage_ctrl with a behavioural ReLU lane array
// beside it (registered output, masked lanes read zero).
module tb_relu_stage_ctrl;

    localparam int DW = 16;
    localparam int AS = 9;
    localparam int CW = 16;
    localparam int VW = DW * AS;

    logic          clk;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_elems;
    logic          busy;
    logic          done;
    logic          s_valid;
    logic          s_ready;
    logic [VW-1:0] s_data;
    logic [VW-1:0] relu_in;
    logic [AS-1:0] relu_en;
    logic [VW-1:0] relu_out;
    logic          m_valid;
    logic          m_ready;
    logic [VW-1:0] m_data;
    logic          m_last;

    int n_vec;
    int n_err;

    relu_stage_ctrl #(
        .DATA_WIDTH (DW),
        .ARRAY_SIZE (AS),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_elems (num_elems),
        .busy      (busy),
        .done      (done),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .relu_in   (relu_in),
        .relu_en   (relu_en),
        .relu_out  (relu_out),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural lane array: one-cycle registered ReLU, disabled lanes give 0.
    always_ff @(posedge clk) begin
        for (int i = 0; i < AS; i++) begin
            if (relu_en[i] && ($signed(relu_in[i*DW +: DW]) > 0)) begin
                relu_out[i*DW +: DW] <= relu_in[i*DW +: DW];
            end else begin
                relu_out[i*DW +: DW] <= '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus lane value for pattern p, beat b, lane i.
    function automatic logic signed [DW-1:0] gen(input int p, input int b, input int i);
        logic signed [DW-1:0] v;
        if (p == 1) begin
            case ((i + b) % 9)
                0:       v = -16'sd3;
                1:       v = 16'sd5;
                2:       v = 16'sd0;
                3:       v = 16'sh8000;
                4:       v = 16'sd7;
                5:       v = 16'sd32767;
                6:       v = -16'sd1;
                7:       v = 16'sd1;
                default: v = 16'sd200;
            endcase
        end else if (p == 2) begin
            v = 16'sd100;
        end else begin
            v = 16'((b * 9 + i) * 37 - 700 + p);
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] in_vec(input int p, input int b);
        logic [VW-1:0] v;
        for (int i = 0; i < AS; i++) v[i*DW +: DW] = gen(p, b, i);
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_vec(input int p, input int b, input int n);
        logic [VW-1:0] v;
        logic signed [DW-1:0] x;
        for (int i = 0; i < AS; i++) begin
            x = gen(p, b, i);
            if ((b * AS + i) >= n || x <= 0) v[i*DW +: DW] = '0;
            else v[i*DW +: DW] = x;
        end
        return v;
    endfunction

    function automatic logic [AS-1:0] exp_mask(input int n, input int b);
        int r;
        logic [AS-1:0] one;
        one = 9'h001;
        r = n - AS * b;
        if (r >= AS) return 9'h1FF;
        return (one << r) - 9'h001;
    endfunction

    // Runs one layer: source always valid, sink stalled for `stall` cycles,
    // optional stray start at cycle `restart_at`. Called just after a posedge.
    task automatic run_layer(input int n, input int p, input int stall,
                             input int restart_at, output int done_c);
        int nb, in_beat, out_beat;
        bit fin;
        nb = (n + AS - 1) / AS;
        in_beat = 0; out_beat = 0; fin = 1'b0; done_c = -1;
        start = 1'b1; num_elems = CW'(n); s_valid = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 400 && !fin; c++) begin
            start     = (c == restart_at);
            num_elems = (c == restart_at) ? CW'(9) : CW'(n);
            m_ready   = (c >= stall);
            s_valid   = 1'b1;
            s_data    = in_vec(p, in_beat);
            #1;
            if (stall > 0 && c == stall - 1) begin
                chk("issued_while_stalled", VW'(in_beat), VW'(2));
                chk("s_ready_stalled", VW'(s_ready), VW'(0));
            end
            if (s_valid && s_ready) begin
                chk("relu_in", relu_in, in_vec(p, in_beat));
                chk("relu_en", VW'(relu_en), VW'(exp_mask(n, in_beat)));
                in_beat++;
            end
            if (m_valid && m_ready) begin
                chk("m_data", m_data, exp_vec(p, out_beat, n));
                chk("m_last", VW'(m_last), VW'(out_beat == nb - 1));
                out_beat++;
            end
            if (done) begin
                fin = 1'b1;
                done_c = c;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; s_valid = 1'b0;
        if (!fin) chk("done_timeout", VW'(0), VW'(1));
        chk("beats_in", VW'(in_beat), VW'(nb));
        chk("beats_out", VW'(out_beat), VW'(nb));
        #1;
        chk("done_one_cycle", VW'(done), VW'(0));
        chk("idle_after_done", VW'(busy), VW'(0));
    endtask

    initial begin
        int dc;
        n_vec = 0; n_err = 0;
        reset = 1'b1; start = 1'b0; num_elems = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_done", VW'(done), VW'(0));
        chk("rst_s_ready", VW'(s_ready), VW'(0));
        chk("rst_m_valid", VW'(m_valid), VW'(0));
        chk("rst_m_last", VW'(m_last), VW'(0));
        chk("rst_relu_en", VW'(relu_en), VW'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: two full beats, mixed signs; done 5 cycles into the run
        run_layer(18, 1, 0, -1, dc);
        chk("t1_done_cycle", VW'(dc), VW'(5));

        // 2: partial tail, 2 live lanes on beat 3
        run_layer(20, 2, 0, -1, dc);

        // 3: sink stalled for 10 cycles
        run_layer(45, 3, 10, -1, dc);

        // 4: empty layer goes straight to DONE
        run_layer(0, 4, 0, -1, dc);
        chk("t4_done_cycle", VW'(dc), VW'(0));

        // 5: reset mid-run with two results buffered
        start = 1'b1; num_elems = CW'(45); s_valid = 1'b1; m_ready = 1'b0;
        s_data = in_vec(5, 0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_buffered", VW'(m_valid), VW'(1));
        chk("t5_busy_before", VW'(busy), VW'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; s_valid = 1'b0;
        #1;
        chk("t5_m_valid", VW'(m_valid), VW'(0));
        chk("t5_s_ready", VW'(s_ready), VW'(0));
        chk("t5_busy", VW'(busy), VW'(0));
        @(posedge clk); #1;
        run_layer(9, 5, 0, -1, dc);

        // 6: stray start during RUN must be ignored (still 3 beats)
        run_layer(27, 6, 0, 1, dc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_relu_stage_ctrl
